hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, branch flush, memory freeze, forwarding select
// Build option HAZARD_FWD_EN enables operand forwarding; without it every EX/MEM dependency stalls.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_ins,
    input  logic        id_valid,
    input  logic        ex_br_ctrl,
    input  logic        mem_busy,
    output logic        pc_stall,
    output logic        id_stall,
    output logic        ex_bubble,
    output logic        id_flush,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LD_STALL = 2'b01,
        ST_BR_FLUSH = 2'b10,
        ST_MEM_WAIT = 2'b11
    } state_t;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

    state_t     state_q, state_d;
    state_t     resume_q, resume_d;
    logic [1:0] cnt_q, cnt_d;

    logic [4:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
    logic       ex_wen_q, ex_wen_d, mem_wen_q, mem_wen_d, wb_wen_q, wb_wen_d;
    logic       ex_ld_q, ex_ld_d, mem_ld_q, mem_ld_d, wb_ld_q, wb_ld_d;

    logic [6:0] opcode;
    logic [4:0] id_rd, id_rs1, id_rs2;
    logic       use_rs1, use_rs2, wr_rd, is_load;
    logic       ex_m1, ex_m2, mem_m1, mem_m2;
    logic       hazard, take_id, frozen;

    assign opcode = id_ins[6:0];
    assign id_rd  = id_ins[11:7];
    assign id_rs1 = id_ins[19:15];
    assign id_rs2 = id_ins[24:20];

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        wr_rd   = 1'b0;
        is_load = 1'b0;
        case (opcode)
            7'b0110011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; wr_rd = 1'b1; end
            7'b0010011: begin use_rs1 = 1'b1; wr_rd = 1'b1; end
            7'b0000011: begin use_rs1 = 1'b1; wr_rd = 1'b1; is_load = 1'b1; end
            7'b0100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            7'b1100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            7'b1100111: begin use_rs1 = 1'b1; wr_rd = 1'b1; end
            7'b0110111: wr_rd = 1'b1;
            7'b0010111: wr_rd = 1'b1;
            7'b1101111: wr_rd = 1'b1;
            default: ;
        endcase
    end

    // x0 is hard-wired zero, so a write to it never creates a dependency
    assign ex_m1  = use_rs1 && ex_wen_q  && (ex_rd_q  != 5'd0) && (ex_rd_q  == id_rs1);
    assign ex_m2  = use_rs2 && ex_wen_q  && (ex_rd_q  != 5'd0) && (ex_rd_q  == id_rs2);
    assign mem_m1 = use_rs1 && mem_wen_q && (mem_rd_q != 5'd0) && (mem_rd_q == id_rs1);
    assign mem_m2 = use_rs2 && mem_wen_q && (mem_rd_q != 5'd0) && (mem_rd_q == id_rs2);

`ifdef HAZARD_FWD_EN
    assign hazard = id_valid && ex_ld_q && (ex_m1 || ex_m2);
`else
    assign hazard = id_valid && (ex_m1 || ex_m2 || mem_m1 || mem_m2);
`endif

    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        cnt_d    = cnt_q;
        take_id  = 1'b0;
        frozen   = 1'b0;
        if (ex_br_ctrl) begin
            state_d = ST_BR_FLUSH;
            cnt_d   = FLUSH_LOAD;
        end else if (mem_busy) begin
            frozen  = 1'b1;
            state_d = ST_MEM_WAIT;
            if (state_q != ST_MEM_WAIT) begin
                resume_d = state_q;
            end
        end else begin
            case (state_q)
                ST_MEM_WAIT: begin
                    frozen  = 1'b1;
                    state_d = resume_q;
                end
                ST_BR_FLUSH: begin
                    if (cnt_q <= 2'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d   = cnt_q - 2'd1;
                    end
                end
                default: begin
                    // LD_STALL re-evaluates the hazard; it clears once the producer moves on
                    if (hazard) begin
                        state_d = ST_LD_STALL;
                    end else begin
                        state_d = ST_RUN;
                        take_id = id_valid;
                    end
                end
            endcase
        end
    end

`ifdef HAZARD_FWD_EN
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
`endif

    always_comb begin
        ex_rd_d   = ex_rd_q;
        ex_wen_d  = ex_wen_q;
        ex_ld_d   = ex_ld_q;
        mem_rd_d  = mem_rd_q;
        mem_wen_d = mem_wen_q;
        mem_ld_d  = mem_ld_q;
        wb_rd_d   = wb_rd_q;
        wb_wen_d  = wb_wen_q;
        wb_ld_d   = wb_ld_q;
`ifdef HAZARD_FWD_EN
        fwd_a_d   = fwd_a_q;
        fwd_b_d   = fwd_b_q;
`endif
        if (!frozen) begin
            ex_rd_d   = id_rd;
            ex_wen_d  = take_id && wr_rd;
            ex_ld_d   = take_id && is_load;
            mem_rd_d  = ex_rd_q;
            mem_wen_d = ex_wen_q;
            mem_ld_d  = ex_ld_q;
            wb_rd_d   = mem_rd_q;
            wb_wen_d  = mem_wen_q;
            wb_ld_d   = mem_ld_q;
`ifdef HAZARD_FWD_EN
            fwd_a_d   = !take_id ? 2'b00 : ex_m1 ? 2'b01 : mem_m1 ? 2'b10 : 2'b00;
            fwd_b_d   = !take_id ? 2'b00 : ex_m2 ? 2'b01 : mem_m2 ? 2'b10 : 2'b00;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            resume_q  <= ST_RUN;
            cnt_q     <= 2'd0;
            ex_rd_q   <= 5'd0;
            ex_wen_q  <= 1'b0;
            ex_ld_q   <= 1'b0;
            mem_rd_q  <= 5'd0;
            mem_wen_q <= 1'b0;
            mem_ld_q  <= 1'b0;
            wb_rd_q   <= 5'd0;
            wb_wen_q  <= 1'b0;
            wb_ld_q   <= 1'b0;
`ifdef HAZARD_FWD_EN
            fwd_a_q   <= 2'b00;
            fwd_b_q   <= 2'b00;
`endif
        end else begin
            state_q   <= state_d;
            resume_q  <= resume_d;
            cnt_q     <= cnt_d;
            ex_rd_q   <= ex_rd_d;
            ex_wen_q  <= ex_wen_d;
            ex_ld_q   <= ex_ld_d;
            mem_rd_q  <= mem_rd_d;
            mem_wen_q <= mem_wen_d;
            mem_ld_q  <= mem_ld_d;
            wb_rd_q   <= wb_rd_d;
            wb_wen_q  <= wb_wen_d;
            wb_ld_q   <= wb_ld_d;
`ifdef HAZARD_FWD_EN
            fwd_a_q   <= fwd_a_d;
            fwd_b_q   <= fwd_b_d;
`endif
        end
    end

`ifdef HAZARD_FWD_EN
    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
`else
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
`endif

    // WB slot is tracked for completeness; write-before-read means it never matches
    logic unused_bits;
    assign unused_bits = ^{id_ins[31:25], id_ins[14:12], wb_rd_q, wb_wen_q, wb_ld_q};

    assign state     = state_q;
    assign pc_stall  = (state_q == ST_LD_STALL) || (state_q == ST_MEM_WAIT);
    assign id_stall  = (state_q == ST_LD_STALL) || (state_q == ST_MEM_WAIT);
    assign ex_bubble = (state_q == ST_LD_STALL) || (state_q == ST_BR_FLUSH);
    assign id_flush  = (state_q == ST_BR_FLUSH);

endmodule
